// File: rtl/m_entry_debounce.sv
// m_entry_debounce
// Conditioning stage ahead of the lock's password FSM. Synchronises the raw
// set button and the 4-bit switch bank, debounces the button with a
// counter-driven FSM, and presents a stretched set_data level plus a code
// word frozen at the moment the press is accepted.
//
// Parameters:
//   DB_CYCLES  stable cycles required to accept a press or a release
//   MIN_HOLD   minimum cycles o_set_data stays high once asserted
// Ports:
//   clk        system clock
//   i_Rst      synchronous active-high reset
//   i_CE       clock enable for FSM, counters and outputs (synchroniser free-runs)
//   i_btn      raw asynchronous push-button, active-high
//   iv_sw      raw asynchronous switch code
//   o_set_data debounced, stretched press level
//   ov_data    code captured at press acceptance
//   o_busy     high whenever the FSM is not idle
// Build option:
//   ENTRY_SW_DEBOUNCE_EN  when defined, each switch bit is stable-filtered
//                         for DB_CYCLES cycles before it can be captured.
module m_entry_debounce #(
  parameter logic [25:0] DB_CYCLES = 26'd100_000,
  parameter logic [25:0] MIN_HOLD  = 26'd5_000_000
) (
  input  logic       clk,
  input  logic       i_Rst,
  input  logic       i_CE,
  input  logic       i_btn,
  input  logic [3:0] iv_sw,
  output logic       o_set_data,
  output logic [3:0] ov_data,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT,
    S_STRETCH
  } state_t;

  state_t      state, state_nxt;
  logic [25:0] db_cnt, db_cnt_nxt;
  logic [25:0] hold_cnt, hold_cnt_nxt;
  logic        set_nxt;
  logic [3:0]  data_nxt;
  logic        busy_nxt;

  logic        btn_meta, btn_s;
  logic [3:0]  sw_meta, sw_s;
  logic [3:0]  sw_cap;

  // Two-flop synchronisers; deliberately not gated by i_CE.
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      sw_meta  <= '0;
      sw_s     <= '0;
    end else begin
      btn_meta <= i_btn;
      btn_s    <= btn_meta;
      sw_meta  <= iv_sw;
      sw_s     <= sw_meta;
    end
  end

`ifdef ENTRY_SW_DEBOUNCE_EN
  logic [3:0]  sw_f;
  logic [25:0] sw_cnt [4];

  // A bit adopts the new synchronised value only after it has disagreed
  // with the filtered value for DB_CYCLES consecutive enabled cycles.
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      sw_f <= '0;
      for (int unsigned i = 0; i < 4; i++) sw_cnt[i] <= '0;
    end else if (i_CE) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sw_s[i] == sw_f[i]) begin
          sw_cnt[i] <= '0;
        end else if (sw_cnt[i] == DB_CYCLES - 26'd1) begin
          sw_f[i]   <= sw_s[i];
          sw_cnt[i] <= '0;
        end else begin
          sw_cnt[i] <= sw_cnt[i] + 26'd1;
        end
      end
    end
  end

  assign sw_cap = sw_f;
`else
  assign sw_cap = sw_s;
`endif

  // State and all counters/outputs advance together only on enabled cycles.
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      state      <= S_IDLE;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      o_set_data <= 1'b0;
      ov_data    <= '0;
      o_busy     <= 1'b0;
    end else if (i_CE) begin
      state      <= state_nxt;
      db_cnt     <= db_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      o_set_data <= set_nxt;
      ov_data    <= data_nxt;
      o_busy     <= busy_nxt;
    end
  end

  logic [25:0] db_inc, hold_inc;
  logic        db_last, hold_done;

  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    hold_cnt_nxt = hold_cnt;
    set_nxt      = o_set_data;
    data_nxt     = ov_data;

    // Both counters saturate rather than wrap.
    db_inc    = (db_cnt < DB_CYCLES) ? db_cnt + 26'd1 : db_cnt;
    hold_inc  = (hold_cnt < MIN_HOLD) ? hold_cnt + 26'd1 : hold_cnt;
    db_last   = (db_cnt == DB_CYCLES - 26'd1);
    hold_done = (hold_cnt >= MIN_HOLD);

    unique case (state)
      S_IDLE: begin
        db_cnt_nxt = '0;
        if (btn_s) state_nxt = S_PRESS_WAIT;
      end
      S_PRESS_WAIT: begin
        // btn_s is checked first so a bounce on the threshold cycle rejects.
        if (!btn_s) begin
          state_nxt  = S_IDLE;
          db_cnt_nxt = '0;
        end else if (db_last) begin
          state_nxt    = S_HELD;
          db_cnt_nxt   = '0;
          hold_cnt_nxt = '0;
          set_nxt      = 1'b1;
          data_nxt     = sw_cap;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      S_HELD: begin
        hold_cnt_nxt = hold_inc;
        if (!btn_s) begin
          state_nxt  = S_RELEASE_WAIT;
          db_cnt_nxt = '0;
        end
      end
      S_RELEASE_WAIT: begin
        hold_cnt_nxt = hold_inc;
        if (btn_s) begin
          state_nxt  = S_HELD;
          db_cnt_nxt = '0;
        end else if (db_last) begin
          db_cnt_nxt = '0;
          if (hold_done) begin
            state_nxt = S_IDLE;
            set_nxt   = 1'b0;
          end else begin
            state_nxt = S_STRETCH;
          end
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      S_STRETCH: begin
        // Button activity is ignored here; a new press starts only from idle.
        if (hold_done) begin
          state_nxt = S_IDLE;
          set_nxt   = 1'b0;
        end else begin
          hold_cnt_nxt = hold_inc;
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        db_cnt_nxt = '0;
        set_nxt    = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_m_entry_debounce.sv
// Testbench for m_entry_debounce (DB_CYCLES=4, MIN_HOLD=8).
// A run-length reference model tracks how long the synchronised button has
// held each level and how many enabled edges have passed since capture; a
// compare process checks every cycle, and directed sections pin literal
// latencies. Set ENTRY_SW_DEBOUNCE_EN to match the RTL build.
module tb_m_entry_debounce;

  localparam int DB  = 4;
  localparam int MIN = 8;

  logic       clk = 1'b0;
  logic       rst, ce, btn;
  logic [3:0] sw;
  logic       o_set_data, o_busy;
  logic [3:0] ov_data;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  m_entry_debounce #(.DB_CYCLES(26'd4), .MIN_HOLD(26'd8)) dut (
    .clk        (clk),
    .i_Rst      (rst),
    .i_CE       (ce),
    .i_btn      (btn),
    .iv_sw      (sw),
    .o_set_data (o_set_data),
    .ov_data    (ov_data),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit       m_s1, m_s2;           // button synchroniser copies
  bit [3:0] m_w1, m_w2;           // switch synchroniser copies
  bit [3:0] m_f;                  // filtered switch value
  int       m_dc [4];             // consecutive disagreeing cycles per bit
  bit       m_active;             // set_data level
  bit [3:0] m_code;
  int       m_prun;               // consecutive high samples seen while not active
  int       m_zrun;               // consecutive low samples seen while active
  bit       m_rel;                // release accepted
  int       m_elapsed;            // enabled edges since capture

  always @(posedge clk) begin
    bit [3:0] cap;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_w1 = 0; m_w2 = 0; m_f = 0;
      for (int i = 0; i < 4; i++) m_dc[i] = 0;
      m_active = 0; m_code = 0; m_prun = 0; m_zrun = 0; m_rel = 0; m_elapsed = 0;
    end else begin
      if (ce) begin
`ifdef ENTRY_SW_DEBOUNCE_EN
        cap = m_f;
`else
        cap = m_w2;
`endif
        if (!m_active) begin
          // Press needs the idle sample plus DB further high samples.
          if (m_s2) begin
            m_prun++;
            if (m_prun == DB + 1) begin
              m_active = 1; m_code = cap; m_elapsed = 0;
              m_zrun = 0; m_rel = 0; m_prun = 0;
            end
          end else begin
            m_prun = 0;
          end
        end else begin
          if (!m_rel) begin
            if (!m_s2) m_zrun++; else m_zrun = 0;
            if (m_zrun == DB + 1) m_rel = 1;
          end
          if (m_rel && m_elapsed >= MIN) m_active = 0;
          m_elapsed++;
        end
        for (int i = 0; i < 4; i++) begin
          if (m_w2[i] != m_f[i]) begin
            m_dc[i]++;
            if (m_dc[i] == DB) begin m_f[i] = m_w2[i]; m_dc[i] = 0; end
          end else begin
            m_dc[i] = 0;
          end
        end
      end
      m_s2 = m_s1; m_s1 = btn;
      m_w2 = m_w1; m_w1 = sw;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_set_data", {31'd0, o_set_data}, {31'd0, m_active});
      check("model_data", {28'd0, ov_data}, {28'd0, m_code});
      check("model_busy", {31'd0, o_busy}, {31'd0, (m_active || m_prun > 0)});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [6:0] pat;
    int       rises;
    bit       prev;
    int       run_left;

    rst = 1; ce = 1; btn = 1; sw = 4'hA;
    @(negedge clk);
    check("reset_set_data", {31'd0, o_set_data}, 32'd0);
    check("reset_data", {28'd0, ov_data}, 32'd0);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    chk_en = 1;
    rst = 0; btn = 0; sw = 4'h5;
    repeat (8) @(negedge clk);

    // Clean press: high for 20 edges, release accepted 7 edges later.
    btn = 1;
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      check("clean_set_data", {31'd0, o_set_data}, {31'd0, (k >= 7 && k <= 26)});
      if (k == 7) check("clean_data", {28'd0, ov_data}, 32'h5);
      @(negedge clk);
      if (k == 20) btn = 0;
    end

    // Short press: release accepted before MIN_HOLD, so STRETCH extends it.
    btn = 1;
    for (int k = 1; k <= 22; k++) begin
      @(posedge clk); #1;
      check("stretch_set_data", {31'd0, o_set_data}, {31'd0, (k >= 7 && k <= 15)});
      @(negedge clk);
      if (k == 8) btn = 0;
    end

    // Bounce rejection: never more than 3 consecutive high samples.
    pat = 7'b0111011;
    for (int k = 0; k < 50; k++) begin
      btn = pat[k % 7];
      @(posedge clk); #1;
      check("bounce_set_data", {31'd0, o_set_data}, 32'd0);
      @(negedge clk);
    end
    btn = 0;
    repeat (10) @(negedge clk);

    // Release glitch: short low pulse must not end the press or recapture.
    sw = 4'h9; repeat (4) @(negedge clk);
    btn = 1; rises = 0; prev = o_set_data;
    for (int k = 1; k <= 56; k++) begin
      @(posedge clk); #1;
      if (o_set_data && !prev) rises++;
      prev = o_set_data;
      check("glitch_set_data", {31'd0, o_set_data}, {31'd0, (k >= 7 && k <= 48)});
      if (k >= 7 && k <= 48) check("glitch_data", {28'd0, ov_data}, 32'h9);
      @(negedge clk);
      if (k == 8) sw = 4'h2;
      if (k == 10) btn = 0;
      if (k == 12) btn = 1;
      if (k == 42) btn = 0;
    end
    check("glitch_rises", rises, 32'd1);

    // Clock-enable gating on alternate cycles.
    repeat (6) @(negedge clk);
    btn = 1;
    for (int k = 1; k <= 20; k++) begin
      ce = k[0];
      @(posedge clk); #1;
      check("ce_set_data", {31'd0, o_set_data}, {31'd0, (k >= 11)});
      @(negedge clk);
    end
    ce = 1; btn = 0;
    repeat (20) @(negedge clk);

    // Switch change two cycles before acceptance.
    sw = 4'h3;
    repeat (10) @(negedge clk);
    btn = 1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
`ifdef ENTRY_SW_DEBOUNCE_EN
      if (k == 7) check("filter_data", {28'd0, ov_data}, 32'h3);
`else
      if (k == 7) check("filter_data", {28'd0, ov_data}, 32'hC);
`endif
      @(negedge clk);
      if (k == 4) sw = 4'hC;
    end
    btn = 0;
    repeat (30) @(negedge clk);

    // Randomised run against the model.
    run_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        btn = ~btn;
        run_left = $urandom_range(1, 14);
      end
      run_left--;
      if ($urandom_range(0, 5) == 0) sw = 4'($urandom_range(0, 15));
      ce  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    rst = 0; ce = 1; btn = 0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
